reset_req_gen: RTL and testbench
================================

RESET_REQ_GEN -- requirements
Module: reset_req_gen

Interface
REQ-001 Parameter HOLD_W, default 16: width of the hold-count input and hold counter.
REQ-002 Parameter SYNC_STAGES, default 2, range 2..4: flop stages synchronizing FAR_RST_N into CLK.
REQ-003 Parameter TIMEOUT, default 1024, range 1..65535: cycles allowed for each far-side acknowledge before abandoning the wait.
REQ-004 Parameter POR_HOLD, default 4, range 1..2^HOLD_W-1: hold count loaded on local reset.
REQ-005 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-006 RST  in  1  reset; synchronous and active-high.
REQ-007 REQ  in  1  request a far-domain reset sequence; sampled only in IDLE.
REQ-008 HOLD_CYCLES  in  HOLD_W  minimum cycles RST_OUT_N is held low; sampled with REQ.
REQ-009 RST_OUT_N  out  1  registered, active-low reset driven to the far domain's reset synchronizer input.
REQ-010 FAR_RST_N  in  1  far domain's synchronized reset status, asynchronous to CLK (0 = far domain in reset).
REQ-011 BUSY  out  1  high whenever state is not IDLE.
REQ-012 DONE  out  1  one-cycle pulse when a sequence completes.
REQ-013 TIMEOUT_ERR  out  1  sticky; set when any acknowledge wait expires.

Function
REQ-014 States: IDLE, HOLD, REL_WAIT; encoding free; all outputs registered.
REQ-015 IDLE: RST_OUT_N=1; REQ=1 -> HOLD next cycle; hold counter loaded with HOLD_CYCLES, or 1 if HOLD_CYCLES=0; timeout counter cleared.
REQ-016 Latency: REQ high in IDLE at edge n -> RST_OUT_N=0 and BUSY=1 after edge n+1.
REQ-017 HOLD: RST_OUT_N=0; hold counter decrements by 1 per cycle and saturates at 0.
REQ-018 HOLD exit: hold counter=0 and synchronized far status=0 -> REL_WAIT.
REQ-019 HOLD timeout: counts only while hold counter=0 and far status=1; on reaching TIMEOUT -> set TIMEOUT_ERR and go to REL_WAIT.
REQ-020 REL_WAIT: RST_OUT_N=1; timeout counter cleared on entry.
REQ-021 REL_WAIT exit: synchronized far status=1 -> IDLE with DONE=1 for exactly one cycle.
REQ-022 REL_WAIT timeout: after TIMEOUT cycles with far status=0 -> set TIMEOUT_ERR, go to IDLE, and pulse DONE.
REQ-023 REQ outside IDLE is ignored and not queued; REQ held high re-triggers on the first IDLE cycle after DONE.
REQ-024 FAR_RST_N passes through SYNC_STAGES flops before use; no combinational path from FAR_RST_N or REQ to any output.
REQ-025 TIMEOUT_ERR clears only on RST; hold and timeout counters never wrap.

Reset
REQ-026 RST=1 at an edge -> state HOLD, hold counter=POR_HOLD, timeout counter=0, RST_OUT_N=0, BUSY=1, DONE=0, TIMEOUT_ERR=0, sync flops=0.
REQ-027 RST asserted mid-sequence aborts the sequence with no DONE pulse; after RST deasserts, a full power-on sequence runs (RST_OUT_N low for at least POR_HOLD cycles).
REQ-028 RST has priority over every other input in the same cycle.

Structure
REQ-029 Shared package holds the state enum type, the timeout counter width (ceil log2(TIMEOUT+1)), and state constants.
REQ-030 One sub-module, sync_bit (SYNC_STAGES-deep level synchronizer, parameterized depth), instantiated once for FAR_RST_N.

Verification
REQ-031 Release RST, far model acks after 3 cycles -> RST_OUT_N low for exactly 4 cycles (POR_HOLD), then high, then DONE pulse; BUSY falls with DONE.
REQ-032 IDLE, REQ=1 with HOLD_CYCLES=10, far acks immediately -> RST_OUT_N low exactly 10 cycles starting at edge n+1; DONE 1 cycle once far status returns high (+SYNC_STAGES).
REQ-033 HOLD_CYCLES=0 -> behaves as 1: RST_OUT_N low at least 1 cycle, sequence completes normally.
REQ-034 Far model never asserts, TIMEOUT=8 -> TIMEOUT_ERR set 8 cycles after hold expiry, REL_WAIT entered, DONE pulses; TIMEOUT_ERR stays 1 across a later good sequence.
REQ-035 REQ pulsed while BUSY (in HOLD and in REL_WAIT) -> no effect; REQ held high continuously -> back-to-back sequences, one IDLE cycle between them.
REQ-036 RST pulsed in REL_WAIT -> no DONE, RST_OUT_N=0 on the next cycle, full POR_HOLD sequence follows.

Source files
------------

// File: rtl/reset_req_gen_pkg.sv
// Shared definitions for the far-domain reset request generator.
// Holds the FSM state type, the state entered on local reset, and the helper
// that sizes the acknowledge-timeout counter from the TIMEOUT parameter.
package reset_req_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_REL_WAIT = 2'd2
  } state_t;

  // Local reset parks the FSM in HOLD so a power-on sequence always runs.
  localparam state_t POR_STATE = ST_HOLD;

  localparam int TIMEOUT_DEF = 1024;

  // Width that can hold 0..timeout inclusive: ceil(log2(timeout+1)).
  function automatic int tmo_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int TMO_W_DEF = tmo_width(TIMEOUT_DEF);

endpackage

// File: rtl/reset_req_gen_if.sv
// Request/status bundle between a requester, the reset generator and the far
// reset domain.
//   req         : level request; only looked at while the generator is idle.
//                 There is no ready: busy=1 means any req is dropped, and a
//                 req still high on the first idle cycle starts a new sequence.
//   hold_cycles : minimum low time of rst_out_n, captured together with req.
//   rst_out_n   : active-low reset toward the far domain (registered).
//   far_rst_n   : far domain's reset status, asynchronous (0 = in reset).
//   busy        : high while a sequence is in progress.
//   done        : one-cycle pulse at sequence end.
//   timeout_err : sticky acknowledge-timeout flag.
// master = requester/far-domain side, slave = generator.
interface reset_req_gen_if #(
  parameter int HOLD_W = 16
);

  logic              req;
  logic [HOLD_W-1:0] hold_cycles;
  logic              rst_out_n;
  logic              far_rst_n;
  logic              busy;
  logic              done;
  logic              timeout_err;

  modport master (
    output req, hold_cycles, far_rst_n,
    input  rst_out_n, busy, done, timeout_err
  );

  modport slave (
    input  req, hold_cycles, far_rst_n,
    output rst_out_n, busy, done, timeout_err
  );

endinterface

// File: rtl/reset_req_gen_sync_bit.sv
// Level synchronizer: STAGES flops in series bringing one asynchronous bit
// into the clk domain. Synchronous reset clears every stage to 0.
//   clk, rst : clock and synchronous active-high reset
//   d        : asynchronous input bit
//   q        : synchronized output (last stage)
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/reset_req_gen.sv
// Generates a reset sequence for a far clock domain: drives rst_out_n low for
// at least the requested hold time and until the far side reports it is in
// reset, then releases and waits for the far side to report it is out of
// reset. Each acknowledge wait is bounded by TIMEOUT cycles.
//   clk       : sole clock
//   rst       : synchronous active-high reset (starts a power-on sequence)
//   bus       : request/status bundle (slave side)
//   state_dbg : current FSM state
module reset_req_gen
  import reset_req_gen_pkg::*;
#(
  parameter int HOLD_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024,
  parameter int POR_HOLD    = 4
) (
  input  logic              clk,
  input  logic              rst,
  reset_req_gen_if.slave    bus,
  output state_t            state_dbg
);

  localparam int                TMO_W    = tmo_width(TIMEOUT);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] POR_CNT  = HOLD_W'(POR_HOLD);

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              far_sync;
  logic              rst_out_n_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_far_sync (
    .clk(clk),
    .rst(rst),
    .d  (bus.far_rst_n),
    .q  (far_sync)
  );

  // Saturating decrement. HOLD exits on the value the counter takes this
  // cycle, so a load of N gives exactly N low cycles when the far side is
  // already in reset.
  always_comb begin
    hold_nxt = hold_cnt;
    if (hold_cnt != '0) begin
      hold_nxt = hold_cnt - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= POR_STATE;
      hold_cnt    <= POR_CNT;
      tmo_cnt     <= '0;
      rst_out_n_q <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            state       <= ST_HOLD;
            // A zero hold request still produces one low cycle.
            hold_cnt    <= (bus.hold_cycles == '0) ? HOLD_W'(1) : bus.hold_cycles;
            tmo_cnt     <= '0;
            rst_out_n_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ST_HOLD: begin
          hold_cnt <= hold_nxt;
          if (hold_nxt == '0 && !far_sync) begin
            state       <= ST_REL_WAIT;
            tmo_cnt     <= '0;
            rst_out_n_q <= 1'b1;
          end else if (hold_cnt == '0 && far_sync) begin
            // Hold time served but far side never entered reset.
            if (tmo_cnt == TMO_LAST) begin
              err_q       <= 1'b1;
              state       <= ST_REL_WAIT;
              tmo_cnt     <= '0;
              rst_out_n_q <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
        end
        ST_REL_WAIT: begin
          if (far_sync) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (tmo_cnt == TMO_LAST) begin
            err_q  <= 1'b1;
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: begin
          state       <= ST_IDLE;
          rst_out_n_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rst_out_n   = rst_out_n_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = err_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_reset_req_gen.sv
// Directed bench for reset_req_gen: power-on sequence, a table of request
// sequences with hand-computed low time and release-to-done latency, and
// hand-written sequences for ignored requests, back-to-back requests, both
// timeouts and reset during release.
module tb_reset_req_gen;
  import reset_req_gen_pkg::*;

  localparam int HOLD_W      = 16;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 8;
  localparam int POR_HOLD    = 4;

  typedef struct {
    logic [HOLD_W-1:0] hc;
    int                delay;
    int                exp_low;
    int                exp_r;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst;
  state_t state_dbg;
  int     n_checks = 0;
  int     n_errors = 0;
  int     far_mode = 0;  // 0: follows rst_out_n after far_delay edges, 1: stuck 1, 2: stuck 0
  int     far_delay = 3;
  logic [7:0] hist;
  logic   far_val;
  logic [15:0] exp_q[$];
  vec_t   vecs[7];

  reset_req_gen_if #(.HOLD_W(HOLD_W)) bus();

  reset_req_gen #(
    .HOLD_W(HOLD_W), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT), .POR_HOLD(POR_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );

  // Clock / far-domain model
  always #5 clk = ~clk;

  always @(posedge clk) hist <= {hist[6:0], bus.rst_out_n};

  always_comb begin
    far_val = 1'b1;
    case (far_mode)
      1: far_val = 1'b1;
      2: far_val = 1'b0;
      default: far_val = (far_delay == 0) ? bus.rst_out_n : hist[far_delay-1];
    endcase
  end

  assign bus.far_rst_n = far_val;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard helpers
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drivers
  task automatic start_req(input string name, input logic [HOLD_W-1:0] hc);
    @(negedge clk);
    bus.req = 1'b1;
    bus.hold_cycles = hc;
    @(negedge clk);
    bus.req = 1'b0;
    chk({name, " latency out_n"}, int'(bus.rst_out_n), 0);
    chk({name, " latency busy"}, int'(bus.busy), 1);
  endtask

  // From a negedge with rst_out_n low; returns total low cycles.
  task automatic wait_release(input int low0, output int low);
    low = low0;
    while (bus.rst_out_n == 1'b0 && low < 300) begin
      @(negedge clk);
      if (bus.rst_out_n == 1'b0) low++;
    end
  endtask

  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (bus.done != 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_done(input string name, input int k, input int exp_k);
    chk({name, " release-to-done"}, k, exp_k);
    chk({name, " busy at done"}, int'(bus.busy), 0);
    chk({name, " out_n at done"}, int'(bus.rst_out_n), 1);
    @(negedge clk);
    chk({name, " done width"}, int'(bus.done), 0);
  endtask

  task automatic run_seq(input string name, input logic [HOLD_W-1:0] hc,
                         input int exp_low, input int exp_r);
    int low, k;
    start_req(name, hc);
    wait_release(1, low);
    chk({name, " low cycles"}, low, exp_low);
    wait_done(0, k);
    check_done(name, k, exp_r);
  endtask

  task automatic por_check(input string name);
    int low, k;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk({name, " rst out_n"}, int'(bus.rst_out_n), 0);
    chk({name, " rst busy"}, int'(bus.busy), 1);
    chk({name, " rst done"}, int'(bus.done), 0);
    chk({name, " rst err"}, int'(bus.timeout_err), 0);
    chk({name, " rst state"}, int'(state_dbg), int'(ST_HOLD));
    rst = 1'b0;
    wait_release(1, low);
    chk({name, " por low cycles"}, low, POR_HOLD);
    wait_done(0, k);
    check_done(name, k, 6);
  endtask

  initial begin
    int low, k;
    rst = 1'b1;
    bus.req = 1'b0;
    bus.hold_cycles = '0;

    // Power-on: far acks 3 cycles after rst_out_n changes.
    far_mode = 0;
    far_delay = 3;
    por_check("por");
    chk("idle state", int'(state_dbg), int'(ST_IDLE));

    // Table: low = max(hc', delay+3), release-to-done = delay+3
    vecs[0] = '{hc: 16'd10, delay: 0, exp_low: 10, exp_r: 3};
    vecs[1] = '{hc: 16'd0,  delay: 0, exp_low: 3,  exp_r: 3};
    vecs[2] = '{hc: 16'd1,  delay: 0, exp_low: 3,  exp_r: 3};
    vecs[3] = '{hc: 16'd5,  delay: 1, exp_low: 5,  exp_r: 4};
    vecs[4] = '{hc: 16'd3,  delay: 4, exp_low: 7,  exp_r: 7};
    vecs[5] = '{hc: 16'd20, delay: 2, exp_low: 20, exp_r: 5};
    vecs[6] = '{hc: 16'd12, delay: 1, exp_low: 12, exp_r: 4};
    for (int i = 0; i < 7; i++) begin
      far_delay = vecs[i].delay;
      exp_q.push_back(16'(vecs[i].exp_low));
      exp_q.push_back(16'(vecs[i].exp_r));
      start_req($sformatf("vec%0d", i), vecs[i].hc);
      wait_release(1, low);
      chk($sformatf("vec%0d low cycles", i), low, int'(exp_q.pop_front()));
      wait_done(0, k);
      check_done($sformatf("vec%0d", i), k, int'(exp_q.pop_front()));
      chk($sformatf("vec%0d err", i), int'(bus.timeout_err), 0);
    end

    // REQ pulsed in HOLD and in REL_WAIT is ignored.
    far_delay = 0;
    start_req("busy_req", 16'd6);
    @(negedge clk);
    bus.req = 1'b1;
    bus.hold_cycles = 16'd40;
    @(negedge clk);
    bus.req = 1'b0;
    chk("busy_req hold state", int'(state_dbg), int'(ST_HOLD));
    chk("busy_req still low", int'(bus.rst_out_n), 0);
    wait_release(3, low);
    chk("busy_req low cycles", low, 6);
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    chk("busy_req rel state", int'(state_dbg), int'(ST_REL_WAIT));
    wait_done(1, k);
    check_done("busy_req", k, 3);
    chk("busy_req not queued", int'(state_dbg), int'(ST_IDLE));
    @(negedge clk);
    chk("busy_req idle out_n", int'(bus.rst_out_n), 1);

    // REQ held high: back-to-back with one IDLE cycle.
    @(negedge clk);
    bus.req = 1'b1;
    bus.hold_cycles = 16'd3;
    @(negedge clk);
    chk("b2b first low", int'(bus.rst_out_n), 0);
    wait_release(1, low);
    chk("b2b first low cycles", low, 3);
    wait_done(0, k);
    chk("b2b idle state at done", int'(state_dbg), int'(ST_IDLE));
    check_done("b2b first", k, 3);
    chk("b2b retrigger state", int'(state_dbg), int'(ST_HOLD));
    chk("b2b retrigger out_n", int'(bus.rst_out_n), 0);
    bus.req = 1'b0;
    wait_release(1, low);
    chk("b2b second low cycles", low, 3);
    wait_done(0, k);
    check_done("b2b second", k, 3);

    // Far side never enters reset: HOLD timeout after 8 cycles.
    far_mode = 1;
    start_req("hold_tmo", 16'd2);
    chk("hold_tmo err before", int'(bus.timeout_err), 0);
    wait_release(1, low);
    chk("hold_tmo low cycles", low, 2 + TIMEOUT);
    chk("hold_tmo err", int'(bus.timeout_err), 1);
    chk("hold_tmo rel state", int'(state_dbg), int'(ST_REL_WAIT));
    wait_done(0, k);
    check_done("hold_tmo", k, 1);

    // Sticky error survives a good sequence.
    far_mode = 0;
    far_delay = 0;
    run_seq("sticky", 16'd4, 4, 3);
    chk("sticky err", int'(bus.timeout_err), 1);

    // RST in REL_WAIT one cycle before DONE would pulse.
    far_delay = 3;
    start_req("rst_rel", 16'd2);
    wait_release(1, low);
    chk("rst_rel low cycles", low, 6);
    repeat (5) @(negedge clk);
    chk("rst_rel pre state", int'(state_dbg), int'(ST_REL_WAIT));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rel out_n", int'(bus.rst_out_n), 0);
    chk("rst_rel state", int'(state_dbg), int'(ST_HOLD));
    chk("rst_rel err cleared", int'(bus.timeout_err), 0);
    for (int i = 0; i < 4; i++) begin
      chk("rst_rel no done", int'(bus.done), 0);
      @(negedge clk);
    end
    rst = 1'b0;
    wait_release(1, low);
    chk("rst_rel por low cycles", low, POR_HOLD);
    wait_done(0, k);
    check_done("rst_rel por", k, 6);

    // Far side stuck in reset: REL_WAIT timeout.
    far_mode = 2;
    repeat (3) @(negedge clk);
    start_req("rel_tmo", 16'd2);
    wait_release(1, low);
    chk("rel_tmo low cycles", low, 2);
    chk("rel_tmo err early", int'(bus.timeout_err), 0);
    wait_done(0, k);
    chk("rel_tmo err", int'(bus.timeout_err), 1);
    check_done("rel_tmo", k, TIMEOUT);
    chk("rel_tmo idle", int'(state_dbg), int'(ST_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
